// File: rtl/jtag_vector_sequencer.sv
// rtl/jtag_vector_sequencer.sv - drives a table of JTAG test vectors into the master and scores captures
module jtag_vector_sequencer #(
  parameter int INSTRUCTION_NUM = 4,
  parameter int DATA_SIZE       = 5,
  parameter int VEC_DEPTH       = 8,
  parameter int RUN_CYCLES      = 32,
  localparam int IW             = $clog2(INSTRUCTION_NUM),
  localparam int AW             = $clog2(VEC_DEPTH)
) (
  input  logic                 tclk,
  input  logic                 trst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [IW-1:0]        cfg_mode,
  input  logic [DATA_SIZE-1:0] cfg_data,
  input  logic [DATA_SIZE-1:0] cfg_expect,
  input  logic [AW:0]          num_vectors,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] output_data,
  output logic [IW-1:0]        test_mode,
  output logic [DATA_SIZE-1:0] input_data,
  output logic                 master_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch_pulse,
  output logic [AW:0]          pass_count,
  output logic [AW:0]          fail_count,
  output logic [AW-1:0]        first_fail_idx,
  output logic                 first_fail_valid
);

  localparam int CW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_mode_mem   [VEC_DEPTH];
  logic [DATA_SIZE-1:0] r_data_mem   [VEC_DEPTH];
  logic [DATA_SIZE-1:0] r_expect_mem [VEC_DEPTH];
  logic [AW-1:0]        r_idx;
  logic [AW:0]          r_n;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_mode;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_mrst_n, r_busy, r_done, r_mismatch, r_ffv;
  logic [AW:0]          r_pass, r_fail;
  logic [AW-1:0]        r_ffi;

  logic [AW:0]          w_eff;
  logic [AW-1:0]        w_next_idx;
  logic                 w_last;
  logic                 w_idle;

  assign w_eff      = (num_vectors > (AW+1)'(VEC_DEPTH)) ? (AW+1)'(VEC_DEPTH) : num_vectors;
  assign w_next_idx = r_idx + 1'b1;
  assign w_last     = ({1'b0, r_idx} + (AW+1)'(1)) == r_n;
  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);

  // Table has no reset; writes are only accepted while no run is in progress.
  always_ff @(posedge tclk) begin
    if (cfg_we && w_idle) begin
      r_mode_mem[cfg_addr]   <= cfg_mode;
      r_data_mem[cfg_addr]   <= cfg_data;
      r_expect_mem[cfg_addr] <= cfg_expect;
    end
  end

  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_data     <= '0;
      r_mrst_n   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_ffi      <= '0;
      r_ffv      <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_mrst_n <= 1'b1;
          if (start) begin
            r_pass <= '0;
            r_fail <= '0;
            r_ffv  <= 1'b0;
            r_ffi  <= '0;
            r_done <= 1'b0;
            r_idx  <= '0;
            r_n    <= w_eff;
            if (w_eff == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_LOAD;
              r_busy   <= 1'b1;
              r_mrst_n <= 1'b0;
              r_mode   <= r_mode_mem[0];
              r_data   <= r_data_mem[0];
            end
          end
        end
        S_LOAD: begin
          r_mrst_n <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          // Compare on the edge entering CHECK so the pulse and counts are visible during CHECK.
          if (r_cnt == CW'(RUN_CYCLES - 1)) begin
            r_state <= S_CHECK;
            if (output_data == r_expect_mem[r_idx]) begin
              if (r_pass < r_n) r_pass <= r_pass + 1'b1;
            end else begin
              r_mismatch <= 1'b1;
              if (r_fail < r_n) r_fail <= r_fail + 1'b1;
              if (!r_ffv) begin
                r_ffv <= 1'b1;
                r_ffi <= r_idx;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx    <= w_next_idx;
            r_mode   <= r_mode_mem[w_next_idx];
            r_data   <= r_data_mem[w_next_idx];
            r_mrst_n <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign test_mode        = r_mode;
  assign input_data       = r_data;
  assign master_rst_n     = r_mrst_n;
  assign busy             = r_busy;
  assign done             = r_done;
  assign mismatch_pulse   = r_mismatch;
  assign pass_count       = r_pass;
  assign fail_count       = r_fail;
  assign first_fail_idx   = r_ffi;
  assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_jtag_vector_sequencer.sv
// tb/tb_jtag_vector_sequencer.sv - self-checking bench for jtag_vector_sequencer
module tb_jtag_vector_sequencer;
  localparam int IW = 2, DW = 5, AW = 3, DEPTH = 8, RUNC = 32, PER = RUNC + 2;

  logic          tclk = 1'b0, trst_n = 1'b0, cfg_we = 1'b0, start = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [IW-1:0] cfg_mode = '0;
  logic [DW-1:0] cfg_data = '0, cfg_expect = '0, corrupt = '0;
  logic [AW:0]   num_vectors = '0;
  logic [DW-1:0] output_data, input_data;
  logic [IW-1:0] test_mode;
  logic          master_rst_n, busy, done, mismatch_pulse, first_fail_valid;
  logic [AW:0]   pass_count, fail_count;
  logic [AW-1:0] first_fail_idx;

  always #5 tclk = ~tclk;
  assign output_data = input_data ^ corrupt;

  jtag_vector_sequencer #(.INSTRUCTION_NUM(4), .DATA_SIZE(DW), .VEC_DEPTH(DEPTH), .RUN_CYCLES(RUNC)) dut (
    .tclk(tclk), .trst_n(trst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_data(cfg_data), .cfg_expect(cfg_expect), .num_vectors(num_vectors), .start(start),
    .output_data(output_data), .test_mode(test_mode), .input_data(input_data),
    .master_rst_n(master_rst_n), .busy(busy), .done(done), .mismatch_pulse(mismatch_pulse),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid));

  int n_cmp = 0, n_bad = 0;
  logic [IW-1:0] sm [DEPTH];
  logic [DW-1:0] sd [DEPTH];
  logic [DW-1:0] se [DEPTH];

  bit mon_en = 1'b0;
  int cyc = 0, busy_cyc = 0, rst_low = 0, mm_cyc = 0;
  int rst_at [$];
  logic [IW+DW-1:0] loaded [$];

  always @(negedge tclk) begin
    cyc++;
    if (mon_en) begin
      if (busy) busy_cyc++;
      if (!master_rst_n) begin
        rst_low++;
        rst_at.push_back(cyc);
        loaded.push_back({test_mode, input_data});
      end
      if (mismatch_pulse) mm_cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_vec(input int a, input logic [IW-1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] e);
    @(negedge tclk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_mode = m; cfg_data = d; cfg_expect = e;
    @(negedge tclk);
    cfg_we = 1'b0;
    sm[a] = m; sd[a] = d; se[a] = e;
  endtask

  // disturb: mid-run start pulse plus a table write to entry 0 that must both be ignored
  task automatic run(input int n, input bit disturb, output int waited);
    @(negedge tclk);
    busy_cyc = 0; rst_low = 0; mm_cyc = 0; rst_at.delete(); loaded.delete();
    mon_en = 1'b1; num_vectors = (AW+1)'(n); start = 1'b1;
    @(negedge tclk);
    start = 1'b0; waited = 0;
    while (!done && waited < 5000) begin
      if (disturb && waited == 40) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
        cfg_mode = ~sm[0]; cfg_data = ~sd[0]; cfg_expect = ~se[0];
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      @(negedge tclk);
      waited++;
    end
    start = 1'b0; cfg_we = 1'b0;
    if (!done) check("run_timeout", 32'(waited), 32'(PER * n));
    mon_en = 1'b0;
  endtask

  task automatic model(input int n, output int nn, output int ep, output int ef, output int effv, output int effi);
    nn = (n > DEPTH) ? DEPTH : n;
    ep = 0; ef = 0; effv = 0; effi = 0;
    for (int i = 0; i < nn; i++) begin
      if ((sd[i] ^ corrupt) == se[i]) ep++;
      else begin
        if (effv == 0) begin effv = 1; effi = i; end
        ef++;
      end
    end
  endtask

  task automatic verify(input string tag, input int n, input int waited);
    int nn, ep, ef, effv, effi;
    model(n, nn, ep, ef, effv, effi);
    check({tag, "_pass"}, 32'(pass_count), 32'(ep));
    check({tag, "_fail"}, 32'(fail_count), 32'(ef));
    check({tag, "_ffv"}, 32'(first_fail_valid), 32'(effv));
    if (effv != 0) check({tag, "_ffi"}, 32'(first_fail_idx), 32'(effi));
    check({tag, "_latency"}, 32'(waited), 32'(PER * nn));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(PER * nn));
    check({tag, "_rst_pulses"}, 32'(rst_low), 32'(nn));
    check({tag, "_mm_pulses"}, 32'(mm_cyc), 32'(ef));
    for (int i = 0; i < loaded.size() && i < nn; i++)
      check({tag, "_loaded"}, 32'(loaded[i]), 32'({sm[i], sd[i]}));
    for (int i = 1; i < rst_at.size(); i++)
      check({tag, "_gap"}, 32'(rst_at[i] - rst_at[i-1]), 32'(PER));
  endtask

  typedef struct {
    int n; logic [DW-1:0] e1; logic [DW-1:0] e2;
    int pass; int fail; int ffv; int ffi; int busy_c; int pulses; int mm;
  } scen_t;

  initial begin
    scen_t sc [3];
    int waited;
    sc[0] = '{3, 5'h15, 5'h1F, 3, 0, 0, 0, 102, 3, 0};
    sc[1] = '{3, 5'h00, 5'h01, 1, 2, 1, 1, 102, 3, 2};
    sc[2] = '{0, 5'h15, 5'h1F, 0, 0, 0, 0, 0, 0, 0};

    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_master_rst_n", 32'(master_rst_n), 0);
    check("rst_counts", 32'({pass_count, fail_count, first_fail_valid, mismatch_pulse}), 0);
    check("rst_drive", 32'({test_mode, input_data}), 0);
    @(negedge tclk); trst_n = 1'b1;
    @(negedge tclk);
    check("idle_master_rst_n", 32'(master_rst_n), 1);

    for (int s = 0; s < 3; s++) begin
      write_vec(0, 2'd1, 5'h0A, 5'h0A);
      write_vec(1, 2'd2, 5'h15, sc[s].e1);
      write_vec(2, 2'd3, 5'h1F, sc[s].e2);
      run(sc[s].n, 1'b0, waited);
      check("tbl_pass", 32'(pass_count), 32'(sc[s].pass));
      check("tbl_fail", 32'(fail_count), 32'(sc[s].fail));
      check("tbl_ffv", 32'(first_fail_valid), 32'(sc[s].ffv));
      check("tbl_ffi", 32'(first_fail_idx), 32'(sc[s].ffi));
      check("tbl_busy_cycles", 32'(busy_cyc), 32'(sc[s].busy_c));
      check("tbl_latency", 32'(waited), 32'(sc[s].busy_c));
      check("tbl_rst_pulses", 32'(rst_low), 32'(sc[s].pulses));
      check("tbl_mm_pulses", 32'(mm_cyc), 32'(sc[s].mm));
      check("tbl_done", 32'(done), 1);
      for (int i = 1; i < rst_at.size(); i++)
        check("tbl_gap", 32'(rst_at[i] - rst_at[i-1]), 34);
    end

    for (int i = 0; i < DEPTH; i++) write_vec(i, IW'(i), DW'(i * 3 + 1), DW'(i * 3 + 1));
    run(12, 1'b0, waited);
    verify("over_depth", 12, waited);
    check("over_depth_total", 32'(pass_count + fail_count), 8);

    @(negedge tclk); num_vectors = 4'd3; start = 1'b1;
    @(negedge tclk); start = 1'b0;
    repeat (PER + 10) @(negedge tclk);
    check("pre_reset_busy", 32'(busy), 1);
    #2 trst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({busy, done, master_rst_n, pass_count, fail_count, first_fail_valid}), 0);
    @(negedge tclk); trst_n = 1'b1;
    @(negedge tclk);
    check("post_reset_idle", 32'({busy, done, master_rst_n}), 1);
    run(3, 1'b0, waited);
    verify("after_reset", 3, waited);

    write_vec(1, 2'd2, 5'h07, 5'h08);
    run(3, 1'b1, waited);
    verify("disturbed", 3, waited);
    run(3, 1'b0, waited);
    verify("rerun", 3, waited);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [DW-1:0] d;
        d = DW'($urandom);
        write_vec(i, IW'($urandom), d, ($urandom_range(0, 2) != 0) ? d : DW'($urandom));
      end
      corrupt = (it == 5) ? DW'($urandom_range(1, 31)) : '0;
      run($urandom_range(0, 15), 1'b0, waited);
      verify("random", int'(num_vectors), waited);
    end
    corrupt = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
